rename_reg_file: RTL and testbench

//  Multi-ported architectural register file with rename (ROB-tag) tracking for a superscalar front end.
//  - ISSUE_W dispatch slots read source operands and claim destination registers each cycle.
//  - COMMIT_W ROB commit ports retire results each cycle.
//  - Intra-bundle dependencies are resolved combinationally.
//  - Commit and dispatch to the same register in one cycle are both honoured.
//  - Sits between the instruction queue (dispatch) and the ROB (commit/rollback).

---
 rtl/rename_reg_file.sv | 152 +++++++++++++++
 tb/tb_rename_reg_file.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rename_reg_file.sv
// rename_reg_file: multi-ported register file with ROB-tag rename tracking; define RF_BYPASS_EN to forward same-cycle commits to table reads
module rename_reg_file #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int TAG_W    = 5,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2,
    parameter int RIDX_W   = $clog2(NREG)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic [ISSUE_W-1:0]           iss_valid,
    input  logic [ISSUE_W*RIDX_W-1:0]    iss_rs1,
    input  logic [ISSUE_W*RIDX_W-1:0]    iss_rs2,
    input  logic [ISSUE_W*RIDX_W-1:0]    iss_rd,
    input  logic [ISSUE_W*TAG_W-1:0]     iss_tag,
    output logic [ISSUE_W-1:0]           iss_bj,
    output logic [ISSUE_W-1:0]           iss_bk,
    output logic [ISSUE_W*TAG_W-1:0]     iss_qj,
    output logic [ISSUE_W*TAG_W-1:0]     iss_qk,
    output logic [ISSUE_W*XLEN-1:0]      iss_vj,
    output logic [ISSUE_W*XLEN-1:0]      iss_vk,
    input  logic [COMMIT_W-1:0]          cm_valid,
    input  logic [COMMIT_W*RIDX_W-1:0]   cm_rd,
    input  logic [COMMIT_W*TAG_W-1:0]    cm_tag,
    input  logic [COMMIT_W*XLEN-1:0]     cm_val,
    input  logic                         rollback
);
    logic [XLEN-1:0]   val_q [NREG];
    logic [XLEN-1:0]   val_d [NREG];
    logic [TAG_W-1:0]  tag_q [NREG];
    logic [TAG_W-1:0]  tag_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [RIDX_W-1:0] i_rs1 [ISSUE_W];
    logic [RIDX_W-1:0] i_rs2 [ISSUE_W];
    logic [RIDX_W-1:0] i_rd  [ISSUE_W];
    logic [TAG_W-1:0]  i_tag [ISSUE_W];
    logic [RIDX_W-1:0] c_rd  [COMMIT_W];
    logic [TAG_W-1:0]  c_tag [COMMIT_W];
    logic [XLEN-1:0]   c_val [COMMIT_W];
    logic [COMMIT_W-1:0] cm_blk;
    logic              rb [ISSUE_W][2];
    logic [TAG_W-1:0]  rq [ISSUE_W][2];
    logic [XLEN-1:0]   rv [ISSUE_W][2];

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_iss
        assign i_rs1[g] = iss_rs1[g*RIDX_W +: RIDX_W];
        assign i_rs2[g] = iss_rs2[g*RIDX_W +: RIDX_W];
        assign i_rd[g]  = iss_rd[g*RIDX_W +: RIDX_W];
        assign i_tag[g] = iss_tag[g*TAG_W +: TAG_W];
        assign iss_bj[g] = rb[g][0];
        assign iss_bk[g] = rb[g][1];
        assign iss_qj[g*TAG_W +: TAG_W] = rq[g][0];
        assign iss_qk[g*TAG_W +: TAG_W] = rq[g][1];
        assign iss_vj[g*XLEN +: XLEN] = rv[g][0];
        assign iss_vk[g*XLEN +: XLEN] = rv[g][1];
    end

    for (genvar g = 0; g < COMMIT_W; g++) begin : g_cm
        assign c_rd[g]  = cm_rd[g*RIDX_W +: RIDX_W];
        assign c_tag[g] = cm_tag[g*TAG_W +: TAG_W];
        assign c_val[g] = cm_val[g*XLEN +: XLEN];
    end

    // A commit may not release a register that some valid slot renames this same cycle
    always_comb begin
        cm_blk = '0;
        for (int j = 0; j < COMMIT_W; j++)
            for (int i = 0; i < ISSUE_W; i++)
                if (iss_valid[i] && i_rd[i] == c_rd[j]) cm_blk[j] = 1'b1;
    end

    // Next state from pre-edge state: commits, then renames (younger wins), then rollback flush
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        for (int j = 0; j < COMMIT_W; j++) begin
            if (cm_valid[j] && c_rd[j] != '0) begin
                val_d[c_rd[j]] = c_val[j];
                if (busy_q[c_rd[j]] && tag_q[c_rd[j]] == c_tag[j] && !cm_blk[j]) begin
                    busy_d[c_rd[j]] = 1'b0;
                    tag_d[c_rd[j]]  = '0;
                end
            end
        end
        for (int i = 0; i < ISSUE_W; i++) begin
            if (iss_valid[i] && i_rd[i] != '0 && !rollback) begin
                busy_d[i_rd[i]] = 1'b1;
                tag_d[i_rd[i]]  = i_tag[i];
            end
        end
        if (rollback) begin
            busy_d = '0;
            tag_d  = '{default: '0};
        end
    end

    // State register; rdy low holds everything
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= '{default: '0};
            tag_q  <= '{default: '0};
            busy_q <= '0;
        end else if (rdy) begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    // Operand read: x0, then youngest older in-bundle producer, then table (optionally commit-bypassed)
    always_comb begin : rd_p
        logic [RIDX_W-1:0] s;
        logic fwd;
        for (int i = 0; i < ISSUE_W; i++) begin
            for (int p = 0; p < 2; p++) begin
                s   = (p != 0) ? i_rs2[i] : i_rs1[i];
                fwd = 1'b0;
                rb[i][p] = 1'b0;
                rq[i][p] = '0;
                rv[i][p] = '0;
                if (iss_valid[i] && s != '0) begin
                    for (int k = 0; k < i; k++) begin
                        if (iss_valid[k] && i_rd[k] == s) begin
                            fwd = 1'b1;
                            rq[i][p] = i_tag[k];
                        end
                    end
                    if (fwd) begin
                        rb[i][p] = 1'b1;
                    end else if (busy_q[s]) begin
                        rb[i][p] = 1'b1;
                        rq[i][p] = tag_q[s];
`ifdef RF_BYPASS_EN
                        for (int j = 0; j < COMMIT_W; j++) begin
                            if (cm_valid[j] && c_rd[j] == s && c_tag[j] == tag_q[s]) begin
                                rb[i][p] = 1'b0;
                                rq[i][p] = '0;
                                rv[i][p] = c_val[j];
                            end
                        end
`endif
                    end else begin
                        rv[i][p] = val_q[s];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rename_reg_file.sv
// tb_rename_reg_file: directed scenarios plus randomized traffic against a behavioural register/rename model
module tb_rename_reg_file;
    logic clk = 1'b0, rst, rdy, rollback;
    logic        iv [2];
    logic [4:0]  irs1 [2], irs2 [2], ird [2], itag [2];
    logic        cv [2];
    logic [4:0]  crd [2], ctag [2];
    logic [31:0] cval [2];
    logic [1:0]  iss_bj, iss_bk;
    logic [9:0]  iss_qj, iss_qk;
    logic [63:0] iss_vj, iss_vk;
    logic [31:0] mval [32];
    logic [4:0]  mtag [32];
    logic        mbusy [32];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    rename_reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iss_valid({iv[1], iv[0]}), .iss_rs1({irs1[1], irs1[0]}), .iss_rs2({irs2[1], irs2[0]}),
        .iss_rd({ird[1], ird[0]}), .iss_tag({itag[1], itag[0]}),
        .iss_bj(iss_bj), .iss_bk(iss_bk), .iss_qj(iss_qj), .iss_qk(iss_qk),
        .iss_vj(iss_vj), .iss_vk(iss_vk),
        .cm_valid({cv[1], cv[0]}), .cm_rd({crd[1], crd[0]}), .cm_tag({ctag[1], ctag[0]}),
        .cm_val({cval[1], cval[0]}), .rollback(rollback)
    );

    task automatic chk(input string t, input logic [37:0] o, input logic [37:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed busy/tag/val %h, expected %h", t, o, e);
        end
    endtask

    function automatic logic [37:0] obs(input int i, input int p);
        return p == 0 ? {iss_bj[i], iss_qj[i*5 +: 5], iss_vj[i*32 +: 32]}
                      : {iss_bk[i], iss_qk[i*5 +: 5], iss_vk[i*32 +: 32]};
    endfunction

    function automatic logic [37:0] exp_rd(input int i, input logic [4:0] s);
        logic [37:0] r;
        if (!iv[i] || s == 0) return '0;
        for (int k = i - 1; k >= 0; k--)
            if (iv[k] && ird[k] == s) return {1'b1, itag[k], 32'h0};
        if (!mbusy[s]) return {1'b0, 5'd0, mval[s]};
        r = {1'b1, mtag[s], 32'h0};
`ifdef RF_BYPASS_EN
        for (int j = 0; j < 2; j++)
            if (cv[j] && crd[j] == s && ctag[j] == mtag[s]) r = {1'b0, 5'd0, cval[j]};
`endif
        return r;
    endfunction

    task automatic idle();
        rst = 0; rdy = 1; rollback = 0;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 0; irs1[i] = 0; irs2[i] = 0; ird[i] = 0; itag[i] = 0;
            cv[i] = 0; crd[i] = 0; ctag[i] = 0; cval[i] = 0;
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            mval[r] = 0; mtag[r] = 0; mbusy[r] = 0;
        end
    endtask

    task automatic tick();
        logic [31:0] nval [32];
        logic [4:0]  ntag [32];
        logic        nbusy [32];
        bit          renamed;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("s%0d.rs1", i), obs(i, 0), exp_rd(i, irs1[i]));
            chk($sformatf("s%0d.rs2", i), obs(i, 1), exp_rd(i, irs2[i]));
        end
        @(posedge clk);
        if (rdy) begin
            nval = mval; ntag = mtag; nbusy = mbusy;
            for (int j = 0; j < 2; j++) begin
                if (cv[j] && crd[j] != 0) begin
                    nval[crd[j]] = cval[j];
                    renamed = (iv[0] && ird[0] == crd[j]) || (iv[1] && ird[1] == crd[j]);
                    if (mbusy[crd[j]] && mtag[crd[j]] == ctag[j] && !renamed) begin
                        nbusy[crd[j]] = 0; ntag[crd[j]] = 0;
                    end
                end
            end
            for (int i = 0; i < 2; i++)
                if (iv[i] && ird[i] != 0 && !rollback) begin
                    nbusy[ird[i]] = 1; ntag[ird[i]] = itag[i];
                end
            if (rollback)
                for (int r = 0; r < 32; r++) begin
                    nbusy[r] = 0; ntag[r] = 0;
                end
            mval = nval; mtag = ntag; mbusy = nbusy;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        // reset state
        iv[0] = 1; irs1[0] = 5; irs2[0] = 31;
        #1 chk("reset x5", obs(0, 0), 38'h0);
        chk("reset x31", obs(0, 1), 38'h0);
        tick();
        // 1: rename x5 -> tag 3, then read it and x0
        idle(); iv[0] = 1; ird[0] = 5; itag[0] = 3;
        tick();
        idle(); iv[0] = 1; irs1[0] = 5; irs2[0] = 0;
        #1 chk("t1 x5 pending", obs(0, 0), {1'b1, 5'd3, 32'h0});
        chk("t1 x0", obs(0, 1), 38'h0);
        tick();
        // 2: intra-bundle dependency and double rename
        idle(); iv[0] = 1; ird[0] = 7; itag[0] = 9; iv[1] = 1; irs1[1] = 7; ird[1] = 7; itag[1] = 10;
        #1 chk("t2 bundle fwd", obs(1, 0), {1'b1, 5'd9, 32'h0});
        tick();
        idle(); iv[0] = 1; irs1[0] = 7;
        #1 chk("t2 younger wins", obs(0, 0), {1'b1, 5'd10, 32'h0});
        tick();
        // 3: matching commit frees, stale commit writes value only
        idle(); cv[0] = 1; crd[0] = 5; ctag[0] = 3; cval[0] = 32'hAB;
        tick();
        idle(); iv[0] = 1; irs1[0] = 5;
        #1 chk("t3 freed", obs(0, 0), {1'b0, 5'd0, 32'hAB});
        tick();
        idle(); iv[0] = 1; ird[0] = 5; itag[0] = 3;
        tick();
        idle(); cv[0] = 1; crd[0] = 5; ctag[0] = 2; cval[0] = 32'hCD;
        tick();
        idle(); iv[0] = 1; irs1[0] = 5;
        #1 chk("t3 stale tag", obs(0, 0), {1'b1, 5'd3, 32'h0});
        tick();
        // 4: commit and rename of same register in one cycle
        idle(); cv[0] = 1; crd[0] = 5; ctag[0] = 3; cval[0] = 32'h77; iv[0] = 1; ird[0] = 5; itag[0] = 4;
        tick();
        idle(); iv[0] = 1; irs1[0] = 5;
        #1 chk("t4 rename wins", obs(0, 0), {1'b1, 5'd4, 32'h0});
        tick();
        // 5: rollback with commit and ignored rename
        idle(); iv[0] = 1; ird[0] = 1; itag[0] = 1; iv[1] = 1; ird[1] = 2; itag[1] = 2;
        tick();
        idle(); rollback = 1; cv[0] = 1; crd[0] = 1; ctag[0] = 1; cval[0] = 7; iv[0] = 1; ird[0] = 3; itag[0] = 6;
        tick();
        idle(); iv[0] = 1; irs1[0] = 1; irs2[0] = 2; iv[1] = 1; irs1[1] = 3; irs2[1] = 5;
        #1 chk("t5 x1", obs(0, 0), {1'b0, 5'd0, 32'h7});
        chk("t5 x2", obs(0, 1), 38'h0);
        chk("t5 x3", obs(1, 0), 38'h0);
        chk("t5 x5 flushed", obs(1, 1), {1'b0, 5'd0, 32'h77});
        tick();
        // 6: commit while reading the same register
        idle(); iv[0] = 1; ird[0] = 5; itag[0] = 3;
        tick();
        idle(); cv[0] = 1; crd[0] = 5; ctag[0] = 3; cval[0] = 32'h55; iv[0] = 1; irs1[0] = 5;
`ifdef RF_BYPASS_EN
        #1 chk("t6 bypass", obs(0, 0), {1'b0, 5'd0, 32'h55});
`else
        #1 chk("t6 no bypass", obs(0, 0), {1'b1, 5'd3, 32'h0});
`endif
        tick();
        // rdy low freezes state
        idle(); rdy = 0; iv[0] = 1; ird[0] = 6; itag[0] = 5; cv[0] = 1; crd[0] = 4; cval[0] = 32'h1234;
        tick();
        idle(); iv[0] = 1; irs1[0] = 6; irs2[0] = 4;
        #1 chk("rdy x6", obs(0, 0), 38'h0);
        chk("rdy x4", obs(0, 1), 38'h0);
        tick();
        // x0 is never written
        idle(); cv[0] = 1; crd[0] = 0; cval[0] = 32'hDEAD; iv[0] = 1; ird[0] = 0; itag[0] = 7;
        tick();
        // randomized traffic on a small register window so collisions are frequent
        for (int n = 0; n < 3000; n++) begin
            idle();
            rdy = ($urandom_range(0, 7) != 0);
            rollback = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 2; i++) begin
                iv[i] = ($urandom_range(0, 3) != 0);
                irs1[i] = 5'($urandom_range(0, 7));
                irs2[i] = 5'($urandom_range(0, 7));
                ird[i] = 5'($urandom_range(0, 7));
                itag[i] = 5'($urandom_range(0, 31));
                cv[i] = $urandom_range(0, 1) == 1;
                crd[i] = 5'($urandom_range(0, 7));
                ctag[i] = $urandom_range(0, 1) == 1 ? mtag[crd[i]] : 5'($urandom_range(0, 31));
                cval[i] = $urandom;
            end
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
